ysyx_24100005_fetch_ctrl: RTL and testbench
===========================================

// Module: ysyx_24100005_fetch_ctrl
// PURPOSE
//   Multi-cycle instruction-fetch sequencer driving the core's PC register.
//   - Issues fetches to instruction memory over a valid/ready request/response handshake.
//   - Holds each returned instruction stable for the execute datapath.
//   - On execute completion, advances PC to PC+4 or to a jump target.
//   - Sits between the imem port and the decode/execute stage.
// PARAMETERS
//   RESET_PC     32'h8000_0000  PC value loaded at reset
//   CNT_W        32             width of retired-instruction counter
//   TIMEOUT_CYC  256            fetch watchdog limit in cycles; used only with FETCH_TIMEOUT_EN
// PORTS
//   clk             in   1   single clock; all state changes on posedge
//   rst             in   1   one clock; reset is synchronous and active-low
//   halt            in   1   1 = stop fetching at the next instruction boundary
//   imem_req_valid  out  1   fetch request valid
//   imem_req_ready  in   1   memory accepts the request
//   imem_addr       out  32  fetch address; equals pc
//   imem_rsp_valid  in   1   response data valid
//   imem_rsp_data   in   32  fetched instruction
//   imem_rsp_ready  out  1   controller accepts the response
//   inst            out  32  latched instruction for the datapath
//   inst_valid      out  1   inst holds a valid instruction awaiting execution
//   exec_done       in   1   datapath has finished inst (sampled only in EXEC)
//   jump_en         in   1   with exec_done: next PC = jump_target
//   jump_target     in   32  redirect address; bits [1:0] forced to 0
//   pc              out  32  current PC
//   idle            out  1   1 while in IDLE
//   icnt            out  CNT_W  retired-instruction count
//   err             out  1   sticky fetch-timeout flag
// BEHAVIOUR
//   States: IDLE, REQ, WAIT, EXEC, HALT.
//   Reset (rst==0 at posedge):
//     state=IDLE, pc=RESET_PC, inst=0, icnt=0, err=0; all valid/ready outputs 0.
//     Reset mid-transaction abandons the transaction; imem must be reset on the same rst.
//   IDLE:
//     idle=1. halt==0 -> REQ next cycle; otherwise remain in IDLE.
//   REQ:
//     imem_req_valid=1; imem_addr=pc, held stable until accepted.
//     imem_req_valid && imem_req_ready -> WAIT.
//   WAIT:
//     imem_rsp_ready=1. On imem_rsp_valid: inst<=imem_rsp_data, -> EXEC.
//     Responses arriving in any other state are ignored.
//   EXEC:
//     inst_valid=1; inst is stable.
//     On exec_done:
//       pc <= jump_en ? {jump_target[31:2],2'b00} : pc+32'd4.
//       PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//       icnt <= icnt+1, wrapping at 2^CNT_W.
//       Next state: halt ? IDLE : REQ.
//   halt is sampled only in IDLE and on the exec_done cycle; it never aborts REQ/WAIT/EXEC.
//   HALT: terminal; all handshake outputs 0. Exit only via reset. Reachable only via timeout.
//   Latency: zero-wait-state memory gives 3 cycles per instruction (REQ, WAIT, EXEC),
//     plus extra cycles while exec_done is held low.
//   Outputs are registered state decodes; no combinational path from inputs to
//     imem_req_valid or inst_valid.
// CONFIGURATION
//   FETCH_TIMEOUT_EN defined:
//     Cycle counter clears on entry to REQ and counts each cycle spent in REQ or WAIT.
//     Reaching TIMEOUT_CYC sets err=1 (sticky) and enters HALT.
//   FETCH_TIMEOUT_EN undefined:
//     No counter; err tied 0; REQ/WAIT wait indefinitely; HALT unreachable.
// TESTING
//   1. Reset, halt=0, memory always ready with 1-cycle response, exec_done=1 each EXEC
//      -> imem_addr sequence 8000_0000, 8000_0004, 8000_0008; one instruction per 3 cycles.
//   2. In EXEC, jump_en=1, jump_target=8000_0103 with exec_done
//      -> next imem_addr=8000_0100; icnt increments by 1.
//   3. imem_req_ready low 5 cycles, then rsp_valid delayed 4 cycles
//      -> imem_addr stable throughout; inst equals the response; no duplicate request.
//   4. halt raised during WAIT
//      -> current instruction completes; state returns to IDLE after exec_done; no new request.
//   5. RESET_PC=32'hFFFF_FFFC, one sequential instruction -> pc wraps to 32'h0000_0000.
//   6. rst=0 pulsed in EXEC -> pc=RESET_PC, inst_valid=0, icnt=0 next cycle.
//      With FETCH_TIMEOUT_EN and imem_req_ready stuck at 0
//      -> err=1 after 256 cycles; state HALT; imem_req_valid=0.

Source files
------------

// File: rtl/ysyx_24100005_fetch_ctrl.sv
// ============================================================================
// Module   : ysyx_24100005_fetch_ctrl
// Brief    : Multi-cycle fetch sequencer (IDLE/REQ/WAIT/EXEC/HALT) owning the PC.
//            Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_24100005_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int          CNT_W       = 32,
  parameter int          TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             imem_rsp_ready,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             exec_done,
  input  logic             jump_en,
  input  logic [31:0]      jump_target,
  output logic [31:0]      pc,
  output logic             idle,
  output logic [CNT_W-1:0] icnt,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_pc;
  logic [31:0]      r_inst;
  logic [CNT_W-1:0] r_icnt;
  logic             w_tmo;
  logic             w_retire;

  assign w_retire = (r_state == S_EXEC) && exec_done;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (!halt)          w_next = S_REQ;
      S_REQ:  if (imem_req_ready) w_next = S_WAIT;
      S_WAIT: if (imem_rsp_valid) w_next = S_EXEC;
      S_EXEC: if (exec_done)      w_next = halt ? S_IDLE : S_REQ;
      S_HALT:                     w_next = S_HALT;
      default:                    w_next = S_IDLE;
    endcase
    // A handshake completing on the final watchdog cycle still wins.
    if (w_tmo && (w_next == r_state)) w_next = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= 32'd0;
      r_icnt  <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_WAIT) && imem_rsp_valid) r_inst <= imem_rsp_data;
      if (w_retire) begin
        r_pc   <= jump_en ? {jump_target[31:2], 2'b00} : r_pc + 32'd4;
        r_icnt <= r_icnt + CNT_W'(1);
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int c_tcnt_w = $clog2(TIMEOUT_CYC + 1);

  logic [c_tcnt_w-1:0] r_tcnt;
  logic                r_err;

  assign w_tmo = ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                 (r_tcnt == c_tcnt_w'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state != S_REQ) && (w_next == S_REQ)) r_tcnt <= '0;
      else if ((r_state == S_REQ) || (r_state == S_WAIT)) r_tcnt <= r_tcnt + c_tcnt_w'(1);
      if (w_next == S_HALT) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYC;
  assign w_tmo        = 1'b0;
  assign err          = 1'b0;
`endif

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_rsp_ready = (r_state == S_WAIT);
  assign inst_valid     = (r_state == S_EXEC);
  assign idle           = (r_state == S_IDLE);
  assign imem_addr      = r_pc;
  assign pc             = r_pc;
  assign inst           = r_inst;
  assign icnt           = r_icnt;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100005_fetch_ctrl.sv
// ============================================================================
// Module   : tb_ysyx_24100005_fetch_ctrl
// Brief    : Directed self-checking bench for the fetch sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_24100005_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        exec_done;
  logic        jump_en;
  logic [31:0] jump_target;

  logic        req_valid, rsp_ready, inst_valid, idle, err;
  logic [31:0] addr, inst, pc, icnt;
  logic        w_req_valid, w_rsp_ready, w_inst_valid, w_idle, w_err;
  logic [31:0] w_addr, w_inst, w_pc, w_icnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24100005_fetch_ctrl u_dut (
    .clk(clk), .rst(rst), .halt(halt),
    .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready), .imem_addr(addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_ready(rsp_ready),
    .inst(inst), .inst_valid(inst_valid), .exec_done(exec_done),
    .jump_en(jump_en), .jump_target(jump_target),
    .pc(pc), .idle(idle), .icnt(icnt), .err(err)
  );

  // Second instance exercises the top-of-address-space wrap.
  ysyx_24100005_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst), .halt(halt),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_ready(w_rsp_ready),
    .inst(w_inst), .inst_valid(w_inst_valid), .exec_done(exec_done),
    .jump_en(jump_en), .jump_target(jump_target),
    .pc(w_pc), .idle(w_idle), .icnt(w_icnt), .err(w_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with the DUT in REQ; leaves it one cycle after retirement.
  task automatic do_inst(input logic [31:0] exp_pc, input logic [31:0] data,
                         input logic jmp, input logic [31:0] tgt);
    chk("req_valid", {31'd0, req_valid}, 32'd1);
    chk("req_addr", addr, exp_pc);
    imem_req_ready = 1'b1;
    tick();
    chk("wait_rsp_ready", {31'd0, rsp_ready}, 32'd1);
    chk("wait_no_req", {31'd0, req_valid}, 32'd0);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    chk("exec_valid", {31'd0, inst_valid}, 32'd1);
    chk("exec_inst", inst, data);
    imem_rsp_valid = 1'b0;
    exec_done      = 1'b1;
    jump_en        = jmp;
    jump_target    = tgt;
    tick();
    exec_done = 1'b0;
    jump_en   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0; halt = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'd0; exec_done = 1'b0; jump_en = 1'b0; jump_target = 32'd0;
    tick(); tick(); tick();

    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'd0);
    chk("rst_icnt", icnt, 32'd0);
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);

    rst = 1'b1;
    tick();
    chk("wrap_req_addr", w_addr, 32'hFFFF_FFFC);
    // Sequential fetches, 3 cycles each, then a jump with misaligned target.
    do_inst(32'h8000_0000, 32'h0000_0013, 1'b0, 32'd0);
    chk("icnt_1", icnt, 32'd1);
    chk("wrap_pc", w_pc, 32'h0000_0000);
    chk("wrap_icnt", w_icnt, 32'd1);
    do_inst(32'h8000_0004, 32'h0010_0093, 1'b0, 32'd0);
    do_inst(32'h8000_0008, 32'h0000_006F, 1'b1, 32'h8000_0103);
    chk("jump_pc", pc, 32'h8000_0100);
    chk("jump_icnt", icnt, 32'd3);

    // Slow memory: request stalled 5 cycles, response 4 cycles late.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req_valid", {31'd0, req_valid}, 32'd1);
      chk("stall_addr", addr, 32'h8000_0100);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_no_dup_req", {31'd0, req_valid}, 32'd0);
      chk("wait_rsp_ready_hold", {31'd0, rsp_ready}, 32'd1);
      chk("wait_addr", addr, 32'h8000_0100);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    chk("slow_inst", inst, 32'hDEAD_BEEF);
    imem_rsp_data = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0;
    chk("exec_ignore_rsp", inst, 32'hDEAD_BEEF);
    chk("exec_hold_valid", {31'd0, inst_valid}, 32'd1);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("seq_pc", pc, 32'h8000_0104);
    chk("seq_icnt", icnt, 32'd4);

    // Halt raised mid-fetch completes the instruction then parks in IDLE.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    halt = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0073;
    tick();
    imem_rsp_valid = 1'b0;
    chk("halt_exec_valid", {31'd0, inst_valid}, 32'd1);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("halt_idle", {31'd0, idle}, 32'd1);
    chk("halt_pc", pc, 32'h8000_0108);
    chk("halt_icnt", icnt, 32'd5);
    tick(); tick();
    chk("halt_no_req", {31'd0, req_valid}, 32'd0);
    chk("halt_still_idle", {31'd0, idle}, 32'd1);
    halt = 1'b0;
    tick();

    // Reset pulsed while executing.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_0001;
    tick();
    imem_rsp_valid = 1'b0;
    chk("pre_rst_exec", {31'd0, inst_valid}, 32'd1);
    rst = 1'b0;
    tick();
    chk("midrst_pc", pc, 32'h8000_0000);
    chk("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("midrst_icnt", icnt, 32'd0);
    chk("midrst_idle", {31'd0, idle}, 32'd1);

`ifdef FETCH_TIMEOUT_EN
    rst = 1'b1;
    tick();
    for (int i = 0; i < 255; i++) tick();
    chk("tmo_err_before", {31'd0, err}, 32'd0);
    chk("tmo_req_before", {31'd0, req_valid}, 32'd1);
    tick();
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_req_valid", {31'd0, req_valid}, 32'd0);
    imem_req_ready = 1'b1;
    tick(); tick();
    chk("tmo_sticky", {31'd0, err}, 32'd1);
    chk("tmo_halt_no_req", {31'd0, req_valid}, 32'd0);
    chk("tmo_halt_not_idle", {31'd0, idle}, 32'd0);
`else
    rst = 1'b1;
    tick();
    chk("no_tmo_err", {31'd0, err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
